// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DM = 1'b1;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data requests.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise data always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic dm_req,
  input  logic take,
  output logic win
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_q;

  // Remembers the most recent winner; reset behaves as if fetch went last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= REQ_IF;
    end else if (take) begin
      last_q <= win;
    end
  end

  always_comb begin
    win = REQ_IF;
    if (if_req && dm_req) begin
      win = (last_q == REQ_DM) ? REQ_IF : REQ_DM;
    end else if (dm_req) begin
      win = REQ_DM;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{clk, rst, take, if_req};

  always_comb begin
    win = REQ_IF;
    if (dm_req) begin
      win = REQ_DM;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data requesters, one access in flight.
// Arbitration policy follows MEM_ARB_ROUND_ROBIN_EN (see mem_arb_pick).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [1:0]        dm_size,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_size,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned LAT =
    (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MIN : MEM_LAT;
  localparam int unsigned CNT_W = $clog2(LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_WAIT = WAIT;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             rvalid_c;
  logic             take_c;
  logic             win_c;

  mem_arb_pick u_pick (
    .clk    (clk),
    .rst    (rst),
    .if_req (if_req),
    .dm_req (dm_req),
    .take   (take_c),
    .win    (win_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      owner_q <= REQ_IF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

  // Grant and memory command are same-cycle; the response is decoded from the counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_size  = '0;

    rvalid_c = (state_q == S_WAIT) && (cnt_q == '0);
    take_c   = !rst && !halt && (if_req || dm_req) &&
               ((state_q == S_IDLE) || rvalid_c);

    if ((state_q == S_WAIT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (rvalid_c) begin
      state_d = S_IDLE;
    end

    if (take_c) begin
      state_d = S_WAIT;
      cnt_d   = CNT_LOAD;
      owner_d = win_c;
      mem_en  = 1'b1;
      if (win_c == REQ_DM) begin
        dm_gnt    = 1'b1;
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
        mem_size  = dm_size;
      end else begin
        if_gnt    = 1'b1;
        mem_addr  = if_addr;
        mem_size  = SZ_W;
      end
    end

    if_rvalid = rvalid_c && (owner_q == REQ_IF);
    dm_rvalid = rvalid_c && (owner_q == REQ_DM);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    dm_rdata  = dm_rvalid ? mem_rdata : '0;
    busy      = (state_q == S_WAIT) || take_c;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a random run
// against a transaction-level model (pending response with a due cycle).
module tb_mem_port_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 3;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          halt;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [1:0]    dm_size;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [1:0]    mem_size;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_size(dm_size), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    halt = 1'b0; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_size = 2'd0;
    mem_rdata = '0;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    idle_inputs();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    next_cycle();
    rst = 1'b1; if_req = 1'b1; dm_req = 1'b1; mem_rdata = 32'hA5A5_5A5A;
    sample();
    total++; if ({if_gnt, dm_gnt} !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b want=00", {if_gnt, dm_gnt}); end
    total++; if ({if_rvalid, dm_rvalid} !== 2'b00) begin bad++; $display("FAIL reset_rvalid got=%b want=00", {if_rvalid, dm_rvalid}); end
    total++; if ({mem_en, mem_we, busy} !== 3'b000) begin bad++; $display("FAIL reset_en_we_busy got=%b want=000", {mem_en, mem_we, busy}); end
    total++; if ({if_rdata, dm_rdata} !== 64'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", {if_rdata, dm_rdata}); end
    total++; if ({mem_addr, mem_wdata, mem_size} !== 66'h0) begin bad++; $display("FAIL reset_mem_cmd got=%h want=0", {mem_addr, mem_wdata, mem_size}); end
    next_cycle();
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single_fetch();
    do_reset();
    if_req = 1'b1; if_addr = 32'h0000_0010;
    sample();
    total++; if ({if_gnt, dm_gnt, mem_en, mem_we, busy} !== 5'b10101) begin bad++; $display("FAIL fetch_gnt got=%b want=10101", {if_gnt, dm_gnt, mem_en, mem_we, busy}); end
    total++; if ({mem_addr, mem_size} !== {32'h0000_0010, 2'd2}) begin bad++; $display("FAIL fetch_cmd got=%h want=%h", {mem_addr, mem_size}, {32'h0000_0010, 2'd2}); end
    for (int k = 1; k <= int'(LAT); k++) begin
      next_cycle();
      if_req = 1'b0;
      mem_rdata = (k == int'(LAT)) ? 32'h0050_0093 : $urandom;
      sample();
      total++; if (if_rvalid !== (k == int'(LAT))) begin bad++; $display("FAIL fetch_rvalid k=%0d got=%b want=%b", k, if_rvalid, k == int'(LAT)); end
      total++; if ({busy, if_gnt, dm_rvalid} !== 3'b100) begin bad++; $display("FAIL fetch_busy k=%0d got=%b want=100", k, {busy, if_gnt, dm_rvalid}); end
      if (k == int'(LAT)) begin
        total++; if (if_rdata !== 32'h0050_0093) begin bad++; $display("FAIL fetch_rdata got=%h want=00500093", if_rdata); end
      end
    end
    next_cycle();
    sample();
    total++; if ({busy, if_rvalid} !== 2'b00) begin bad++; $display("FAIL fetch_after got=%b want=00", {busy, if_rvalid}); end
  endtask

  task automatic test_store();
    do_reset();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_size = 2'd2;
    sample();
    total++; if ({dm_gnt, if_gnt, mem_en, mem_we} !== 4'b1011) begin bad++; $display("FAIL store_gnt got=%b want=1011", {dm_gnt, if_gnt, mem_en, mem_we}); end
    total++; if ({mem_addr, mem_wdata, mem_size} !== {32'h100, 32'hDEAD_BEEF, 2'd2}) begin bad++; $display("FAIL store_cmd got=%h want=%h", {mem_addr, mem_wdata, mem_size}, {32'h100, 32'hDEAD_BEEF, 2'd2}); end
    next_cycle();
    dm_we = 1'b0; dm_addr = 32'h200; dm_wdata = 32'h0; dm_size = 2'd1;
    for (int k = 1; k <= int'(LAT); k++) begin
      if (k > 1) next_cycle();
      sample();
      total++; if ({dm_gnt, mem_en, dm_rvalid} !== {3{k == int'(LAT)}}) begin bad++; $display("FAIL store_wait k=%0d got=%b want=%b", k, {dm_gnt, mem_en, dm_rvalid}, {3{k == int'(LAT)}}); end
      if (k < int'(LAT)) begin
        total++; if ({mem_we, mem_addr, mem_wdata, mem_size} !== 67'h0) begin bad++; $display("FAIL store_idle_cmd k=%0d got=%h want=0", k, {mem_we, mem_addr, mem_wdata, mem_size}); end
      end else begin
        total++; if ({mem_we, mem_addr} !== {1'b0, 32'h200}) begin bad++; $display("FAIL store_next_load got=%h want=%h", {mem_we, mem_addr}, {1'b0, 32'h200}); end
      end
    end
  endtask

  task automatic test_conflict();
    int   n = 0;
    logic order [4];
    do_reset();
    if_req = 1'b1; if_addr = 32'h40; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80; dm_size = 2'd2;
    for (int cy = 0; cy < 40 && n < 4; cy++) begin
      if (cy > 0) next_cycle();
      sample();
      if (if_gnt || dm_gnt) begin
        total++; if (if_gnt && dm_gnt) begin bad++; $display("FAIL conflict_both got=11 want=one-hot"); end
        order[n] = dm_gnt;
        n++;
      end
    end
    total++; if (n != 4) begin bad++; $display("FAIL conflict_timeout got=%0d want=4 grants", n); end
    for (int i = 0; i < n; i++) begin
      total++; if (order[i] !== (RR ? (i % 2 == 0) : 1'b1)) begin bad++; $display("FAIL conflict_order i=%0d got_dm=%b want_dm=%b", i, order[i], RR ? (i % 2 == 0) : 1'b1); end
    end
  endtask

  task automatic test_halt();
    do_reset();
    if_req = 1'b1; if_addr = 32'h20;
    sample();
    total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL halt_first_gnt got=%b want=1", if_gnt); end
    next_cycle();
    halt = 1'b1;
    for (int k = 1; k <= int'(LAT) + 2; k++) begin
      if (k > 1) next_cycle();
      sample();
      total++; if ({if_gnt, dm_gnt, mem_en} !== 3'b000) begin bad++; $display("FAIL halt_gnt k=%0d got=%b want=000", k, {if_gnt, dm_gnt, mem_en}); end
      total++; if (if_rvalid !== (k == int'(LAT))) begin bad++; $display("FAIL halt_rvalid k=%0d got=%b want=%b", k, if_rvalid, k == int'(LAT)); end
    end
    next_cycle();
    halt = 1'b0;
    sample();
    total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL halt_resume got=%b want=1", if_gnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40; dm_size = 2'd0;
    sample();
    total++; if (dm_gnt !== 1'b1) begin bad++; $display("FAIL rmid_gnt got=%b want=1", dm_gnt); end
    next_cycle();
    rst = 1'b1; mem_rdata = 32'h1234_5678;
    for (int k = 0; k <= int'(LAT); k++) begin
      if (k > 0) next_cycle();
      sample();
      total++; if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we, busy, if_rdata, dm_rdata, mem_addr} !== 103'h0) begin
        bad++; $display("FAIL rmid_outputs k=%0d got=%h want=0", k, {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we, busy, if_rdata, dm_rdata, mem_addr});
      end
    end
    next_cycle();
    rst = 1'b0;
    sample();
    total++; if ({dm_gnt, mem_addr} !== {1'b1, 32'h40}) begin bad++; $display("FAIL rmid_regrant got=%h want=%h", {dm_gnt, mem_addr}, {1'b1, 32'h40}); end
    for (int k = 1; k <= int'(LAT); k++) begin
      next_cycle();
      dm_req = 1'b0;
      sample();
      total++; if (dm_rvalid !== (k == int'(LAT))) begin bad++; $display("FAIL rmid_rvalid k=%0d got=%b want=%b", k, dm_rvalid, k == int'(LAT)); end
    end
  endtask

  task automatic test_back_to_back();
    int   ng = 0;
    logic eg, ev;
    do_reset();
    if_req = 1'b1; if_addr = 32'h1000;
    for (int c = 0; c <= 3 * int'(LAT); c++) begin
      if (c > 0) begin
        next_cycle();
        if (ng == 3) if_req = 1'b0;
        if_addr = if_addr + 32'd4;
      end
      sample();
      eg = (c % int'(LAT) == 0) && (c < 3 * int'(LAT));
      ev = (c > 0) && (c % int'(LAT) == 0);
      total++; if (if_gnt !== eg) begin bad++; $display("FAIL b2b_gnt c=%0d got=%b want=%b", c, if_gnt, eg); end
      total++; if (if_rvalid !== ev) begin bad++; $display("FAIL b2b_rvalid c=%0d got=%b want=%b", c, if_rvalid, ev); end
      if (eg) ng++;
    end
  endtask

  task automatic test_random(input int n);
    bit            ov = 1'b0, ip = 1'b0, dp = 1'b0, can;
    int            due = 0;
    logic          who = 1'b0, who_we = 1'b0, last = 1'b0, w;
    logic          exp_rv, exp_ig, exp_dg;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic [1:0]    exp_size;
    do_reset();
    for (int c = 0; c < n; c++) begin
      if (c > 0) next_cycle();
      if (!ip && $urandom_range(0, 2) != 0) begin ip = 1'b1; if_addr = $urandom; end
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp = 1'b1; dm_we = 1'($urandom); dm_addr = $urandom; dm_wdata = $urandom; dm_size = 2'($urandom_range(0, 2));
      end
      if_req = ip; dm_req = dp;
      halt = ($urandom_range(0, 4) == 0);
      mem_rdata = $urandom;
      sample();
      exp_rv = ov && (due == c);
      can    = !halt && (ip || dp) && (!ov || exp_rv);
      w      = (ip && dp) ? (RR ? !last : 1'b1) : dp;
      exp_ig = can && !w;
      exp_dg = can && w;
      exp_addr  = exp_ig ? if_addr : (exp_dg ? dm_addr : '0);
      exp_wdata = exp_dg ? dm_wdata : '0;
      exp_size  = exp_ig ? 2'd2 : (exp_dg ? dm_size : 2'd0);
      total++; if ({if_gnt, dm_gnt} !== {exp_ig, exp_dg}) begin bad++; $display("FAIL rnd_gnt c=%0d got=%b want=%b", c, {if_gnt, dm_gnt}, {exp_ig, exp_dg}); end
      total++; if ({mem_en, mem_we} !== {can, exp_dg && dm_we}) begin bad++; $display("FAIL rnd_en_we c=%0d got=%b want=%b", c, {mem_en, mem_we}, {can, exp_dg && dm_we}); end
      total++; if ({mem_addr, mem_wdata, mem_size} !== {exp_addr, exp_wdata, exp_size}) begin bad++; $display("FAIL rnd_cmd c=%0d got=%h want=%h", c, {mem_addr, mem_wdata, mem_size}, {exp_addr, exp_wdata, exp_size}); end
      total++; if ({if_rvalid, dm_rvalid} !== {exp_rv && !who, exp_rv && who}) begin bad++; $display("FAIL rnd_rvalid c=%0d got=%b want=%b", c, {if_rvalid, dm_rvalid}, {exp_rv && !who, exp_rv && who}); end
      total++; if (busy !== (ov || can)) begin bad++; $display("FAIL rnd_busy c=%0d got=%b want=%b", c, busy, ov || can); end
      if (exp_rv && !who) begin
        total++; if (if_rdata !== mem_rdata) begin bad++; $display("FAIL rnd_if_rdata c=%0d got=%h want=%h", c, if_rdata, mem_rdata); end
      end
      if (exp_rv && who && !who_we) begin
        total++; if (dm_rdata !== mem_rdata) begin bad++; $display("FAIL rnd_dm_rdata c=%0d got=%h want=%h", c, dm_rdata, mem_rdata); end
      end
      if (exp_rv) ov = 1'b0;
      if (can) begin
        ov = 1'b1; due = c + int'(LAT); who = w; last = w; who_we = w && dm_we;
        if (w) dp = 1'b0; else ip = 1'b0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_store();
    test_conflict();
    test_halt();
    test_reset_mid();
    test_back_to_back();
    test_random(400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
